// File: rtl/commit_trace_buffer.sv
// Retirement trace FIFO: captures {pc, result} from writeback, drains over valid/ready.
// Overflow drops the newest commit and is recorded in a sticky flag and a saturating counter.
module commit_trace_buffer #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH         = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       commit_valid_i,
    input  logic [ADDRESS_WIDTH-1:0]   pc_i,
    input  logic [DATA_WIDTH-1:0]      result_i,
    input  logic                       clr_i,
    input  logic                       trace_ready_i,
    output logic                       trace_valid_o,
    output logic [ADDRESS_WIDTH-1:0]   trace_pc_o,
    output logic [DATA_WIDTH-1:0]      trace_result_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       overflow_o,
    output logic [CNT_WIDTH-1:0]       drop_cnt_o,
    output logic [CNT_WIDTH-1:0]       commit_cnt_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDRESS_WIDTH + DATA_WIDTH;

    localparam logic [OCC_W-1:0]     OCC_FULL = OCC_W'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [OCC_W-1:0]     occ;
    logic [CNT_WIDTH-1:0] drop_cnt;
    logic [CNT_WIDTH-1:0] commit_cnt;
    logic                 overflow;

    logic                 pop;
    logic                 push;
    logic                 drop;
    logic [ENTRY_W-1:0]   head;

    assign empty_o       = (occ == '0);
    assign full_o        = (occ == OCC_FULL);
    assign trace_valid_o = !empty_o;
    assign count_o       = occ;

    assign pop  = trace_valid_o && trace_ready_i;
    // A full FIFO that is popping this cycle frees a slot for the commit.
    assign push = commit_valid_i && (!full_o || pop);
    assign drop = commit_valid_i && full_o && !pop;

    assign head           = mem[rd_ptr];
    assign trace_pc_o     = empty_o ? '0 : head[ENTRY_W-1:DATA_WIDTH];
    assign trace_result_o = empty_o ? '0 : head[DATA_WIDTH-1:0];

    assign overflow_o   = overflow;
    assign drop_cnt_o   = drop_cnt;
    assign commit_cnt_o = commit_cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {pc_i, result_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // A clear cycle restarts the statistics, so its own commit/drop counts as the first.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt   <= '0;
            commit_cnt <= '0;
            overflow   <= 1'b0;
        end else if (clr_i) begin
            drop_cnt   <= drop ? CNT_ONE : '0;
            commit_cnt <= commit_valid_i ? CNT_ONE : '0;
            overflow   <= drop;
        end else begin
            if (drop && drop_cnt != CNT_MAX) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (commit_valid_i) begin
                commit_cnt <= commit_cnt + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: fill, drain, overflow, wrap, clear and reset.
// Expected values are hand-derived; the wrap test uses a small queue model.
module tb_commit_trace_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid_i;
    logic [31:0] pc_i;
    logic [31:0] result_i;
    logic        clr_i;
    logic        trace_ready_i;
    logic        trace_valid_o;
    logic [31:0] trace_pc_o;
    logic [31:0] trace_result_o;
    logic [4:0]  count_o;
    logic        full_o;
    logic        empty_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;
    logic [15:0] commit_cnt_o;

    int passed = 0;
    int total  = 0;

    logic [63:0] q [$];

    commit_trace_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .commit_valid_i (commit_valid_i),
        .pc_i           (pc_i),
        .result_i       (result_i),
        .clr_i          (clr_i),
        .trace_ready_i  (trace_ready_i),
        .trace_valid_o  (trace_valid_o),
        .trace_pc_o     (trace_pc_o),
        .trace_result_o (trace_result_o),
        .count_o        (count_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .overflow_o     (overflow_o),
        .drop_cnt_o     (drop_cnt_o),
        .commit_cnt_o   (commit_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        commit_valid_i = 1'b0;
        pc_i           = '0;
        result_i       = '0;
        clr_i          = 1'b0;
        trace_ready_i  = 1'b0;

        // Reset state
        do_reset();
        chk("rst_valid", trace_valid_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_pc", trace_pc_o, 0);
        chk("rst_result", trace_result_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        chk("rst_commit", commit_cnt_o, 0);
        chk("rst_ovf", overflow_o, 0);

        // T1: three commits, consumer stalled
        commit_valid_i = 1'b1;
        pc_i = 32'h0; result_i = 32'd1;
        step();
        chk("t1_latency_pc", trace_pc_o, 32'h0);
        chk("t1_latency_cnt", count_o, 1);
        pc_i = 32'h4; result_i = 32'd2;
        step();
        pc_i = 32'h8; result_i = 32'd3;
        step();
        commit_valid_i = 1'b0;
        chk("t1_count", count_o, 3);
        chk("t1_head_pc", trace_pc_o, 32'h0);
        chk("t1_head_res", trace_result_o, 32'd1);
        chk("t1_commit", commit_cnt_o, 3);

        // T2: drain in order
        trace_ready_i = 1'b1;
        chk("t2_pc0", trace_pc_o, 32'h0);
        step();
        chk("t2_pc1", trace_pc_o, 32'h4);
        chk("t2_res1", trace_result_o, 32'd2);
        step();
        chk("t2_pc2", trace_pc_o, 32'h8);
        chk("t2_res2", trace_result_o, 32'd3);
        step();
        chk("t2_empty", empty_o, 1);
        chk("t2_valid", trace_valid_o, 0);
        chk("t2_pc_zero", trace_pc_o, 0);
        chk("t2_res_zero", trace_result_o, 0);
        step();
        chk("t2_idle_count", count_o, 0);
        trace_ready_i = 1'b0;

        // T3: 20 commits into 16 entries
        do_reset();
        commit_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pc_i     = 32'h100 + 32'(4 * i);
            result_i = 32'd100 + 32'(i);
            step();
            if (i == 15) begin
                chk("t3_full_at16", full_o, 1);
                chk("t3_no_drop_yet", drop_cnt_o, 0);
            end
        end
        commit_valid_i = 1'b0;
        chk("t3_full", full_o, 1);
        chk("t3_count", count_o, 16);
        chk("t3_drop", drop_cnt_o, 4);
        chk("t3_ovf", overflow_o, 1);
        chk("t3_commit", commit_cnt_o, 20);
        chk("t3_head_pc", trace_pc_o, 32'h100);
        chk("t3_head_res", trace_result_o, 32'd100);

        // T4: commit while full and popping
        commit_valid_i = 1'b1;
        pc_i = 32'h999; result_i = 32'habc;
        trace_ready_i = 1'b1;
        step();
        commit_valid_i = 1'b0;
        chk("t4_count", count_o, 16);
        chk("t4_drop", drop_cnt_o, 4);
        chk("t4_commit", commit_cnt_o, 21);
        for (int i = 1; i < 16; i++) begin
            chk("t4_order_pc", trace_pc_o, 32'h100 + 32'(4 * i));
            step();
        end
        chk("t4_last_pc", trace_pc_o, 32'h999);
        chk("t4_last_res", trace_result_o, 32'habc);
        step();
        chk("t4_empty", empty_o, 1);
        trace_ready_i = 1'b0;

        // T5: 40 commits with random stalls on both sides
        begin
            int  pushed = 0;
            int  sz;
            bit  popping;
            logic [63:0] exp;
            for (int cyc = 0; cyc < 600 && (pushed < 40 || q.size() != 0);
                 cyc++) begin
                commit_valid_i = (pushed < 40) && ($urandom_range(0, 3) != 0);
                pc_i           = 32'h1000 + 32'(4 * pushed);
                result_i       = 32'hA000 + 32'(pushed);
                trace_ready_i  = ($urandom_range(0, 2) != 0);
                sz             = q.size();
                chk("t5_valid", trace_valid_o, 64'(sz != 0));
                chk("t5_count", count_o, 64'(sz));
                popping = trace_ready_i && sz != 0;
                if (popping) begin
                    exp = q.pop_front();
                    chk("t5_pc", trace_pc_o, exp[63:32]);
                    chk("t5_res", trace_result_o, exp[31:0]);
                end
                if (commit_valid_i) begin
                    if (sz < 16 || popping) q.push_back({pc_i, result_i});
                    pushed++;
                end
                step();
            end
            commit_valid_i = 1'b0;
            trace_ready_i  = 1'b0;
            chk("t5_done", q.size(), 0);
            chk("t5_all_pushed", pushed, 40);
        end

        // T6: clear with concurrent commit, then reset mid-drain
        commit_valid_i = 1'b1;
        pc_i = 32'h500; result_i = 32'd5;
        step();
        pc_i = 32'h504; result_i = 32'd6;
        step();
        chk("t6_ovf_before", overflow_o, 1);
        clr_i = 1'b1;
        pc_i = 32'h508; result_i = 32'd7;
        step();
        clr_i = 1'b0;
        commit_valid_i = 1'b0;
        chk("t6_commit", commit_cnt_o, 1);
        chk("t6_drop", drop_cnt_o, 0);
        chk("t6_ovf", overflow_o, 0);
        chk("t6_count", count_o, 3);
        chk("t6_head_pc", trace_pc_o, 32'h500);
        trace_ready_i = 1'b1;
        step();
        chk("t6_pc1", trace_pc_o, 32'h504);
        chk("t6_res1", trace_result_o, 32'd6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_valid", trace_valid_o, 0);
        chk("t6_rst_count", count_o, 0);
        chk("t6_rst_commit", commit_cnt_o, 0);
        chk("t6_rst_drop", drop_cnt_o, 0);
        chk("t6_rst_pc", trace_pc_o, 0);
        step();
        chk("t6_idle_valid", trace_valid_o, 0);
        trace_ready_i = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
